// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD read and write drivers: mode codes, FSM states,
// busy-flag position and the controller instruction set.
package lcd_pkg;

  localparam logic [1:0] MODE_STATUS = 2'b00;
  localparam logic [1:0] MODE_DATA   = 2'b01;
  localparam logic [1:0] MODE_POLL   = 2'b10;

  localparam int unsigned BF_BIT = 7;

  localparam logic [7:0] CMD_CLEAR       = 8'h01;
  localparam logic [7:0] CMD_HOME        = 8'h02;
  localparam logic [7:0] CMD_ENTRY_MODE  = 8'h06;
  localparam logic [7:0] CMD_DISPLAY_ON  = 8'h0C;
  localparam logic [7:0] CMD_FUNC_4BIT   = 8'h28;
  localparam logic [7:0] CMD_FUNC_8BIT   = 8'h38;
  localparam logic [7:0] CMD_SET_DDRAM   = 8'h80;

  typedef enum logic [2:0] {
    StIdle, StReq, StSetup, StEHigh, StHold, StDone
  } rdState_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter timing one bus phase; done is high during the last cycle of the phase.
module lcd_phase_timer #(
  parameter int unsigned Width = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] loadVal,
  output logic             done
);

  logic [Width-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= loadVal;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == Width'(1));

endmodule

// File: rtl/lcd_status_reader.sv
// HD44780 read-cycle engine (status, data, poll-until-not-busy) sharing the LCD pins via busReq/busGnt.
// Define LCD_READ_4BIT_EN for the 4-bit bus: two nibble cycles per byte on lcdDataIn[7:4].
module lcd_status_reader
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned EHIGH_CYC = 4,
  parameter int unsigned HOLD_CYC  = 2,
  parameter int unsigned MAX_POLLS = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode,
  output logic       ready,
  output logic       rdValid,
  output logic [7:0] rdData,
  output logic       busyFlag,
  output logic [6:0] addrCnt,
  output logic       timeout,
  output logic       busReq,
  input  logic       busGnt,
  input  logic [7:0] lcdDataIn,
  output logic       lcdRS,
  output logic       lcdRW,
  output logic       lcdE
);

  localparam int unsigned PhW = $clog2(max3(SETUP_CYC, EHIGH_CYC, HOLD_CYC) + 1);
  localparam int unsigned PcW = $clog2(MAX_POLLS + 1);

  rdState_e       state;
  logic [1:0]     modeQ;
  logic [PcW-1:0] pollCnt;
  logic [7:0]     sampled;
  logic           tmrLoad;
  logic [PhW-1:0] tmrVal;
  logic           tmrDone;
  logic           rePoll;
  logic           moreNib;

`ifdef LCD_READ_4BIT_EN
  logic nibLow;
  assign moreNib = !nibLow;
`else
  assign moreNib = 1'b0;
`endif

  assign rePoll = (modeQ == MODE_POLL) && sampled[BF_BIT] &&
                  (pollCnt < PcW'(MAX_POLLS - 1));

  // Timer is reloaded on the same edge the FSM enters the next phase.
  always_comb begin
    tmrLoad = 1'b0;
    tmrVal  = PhW'(SETUP_CYC);
    unique case (state)
      StReq:   tmrLoad = busGnt;
      StSetup: begin
        tmrLoad = tmrDone;
        tmrVal  = PhW'(EHIGH_CYC);
      end
      StEHigh: begin
        tmrLoad = tmrDone;
        tmrVal  = PhW'(HOLD_CYC);
      end
      StHold:  tmrLoad = tmrDone && (moreNib || rePoll);
      default: ;
    endcase
  end

  lcd_phase_timer #(
    .Width(PhW)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmrLoad),
    .loadVal(tmrVal),
    .done   (tmrDone)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= StIdle;
      modeQ    <= MODE_STATUS;
      pollCnt  <= '0;
      sampled  <= '0;
      ready    <= 1'b1;
      rdValid  <= 1'b0;
      rdData   <= '0;
      busyFlag <= 1'b0;
      addrCnt  <= '0;
      timeout  <= 1'b0;
      busReq   <= 1'b0;
      lcdRS    <= 1'b0;
      lcdRW    <= 1'b0;
      lcdE     <= 1'b0;
`ifdef LCD_READ_4BIT_EN
      nibLow   <= 1'b0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          if (start) begin
            modeQ  <= (mode == 2'b11) ? MODE_STATUS : mode;
            ready  <= 1'b0;
            busReq <= 1'b1;
            state  <= StReq;
          end
        end
        StReq: begin
          if (busGnt) begin
            lcdRW <= 1'b1;
            lcdRS <= (modeQ == MODE_DATA);
            state <= StSetup;
          end
        end
        StSetup: begin
          if (tmrDone) begin
            lcdE  <= 1'b1;
            state <= StEHigh;
          end
        end
        StEHigh: begin
          if (tmrDone) begin
            lcdE  <= 1'b0;
            state <= StHold;
`ifdef LCD_READ_4BIT_EN
            if (nibLow) sampled[3:0] <= lcdDataIn[7:4];
            else        sampled[7:4] <= lcdDataIn[7:4];
`else
            sampled <= lcdDataIn;
`endif
          end
        end
        StHold: begin
          if (tmrDone) begin
`ifdef LCD_READ_4BIT_EN
            nibLow <= ~nibLow;
`endif
            if (moreNib) begin
              state <= StSetup;
            end else if (rePoll) begin
              pollCnt <= pollCnt + 1'b1;
              state   <= StSetup;
            end else begin
              rdValid <= 1'b1;
              rdData  <= sampled;
              timeout <= (modeQ == MODE_POLL) && sampled[BF_BIT];
              lcdRW   <= 1'b0;
              lcdRS   <= 1'b0;
              if (modeQ != MODE_DATA) begin
                busyFlag <= sampled[BF_BIT];
                addrCnt  <= sampled[6:0];
              end
              state <= StDone;
            end
          end
        end
        StDone: begin
          rdValid <= 1'b0;
          timeout <= 1'b0;
          busReq  <= 1'b0;
          ready   <= 1'b1;
          pollCnt <= '0;
          state   <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_status_reader.sv
// Directed bench for lcd_status_reader (default 8-bit build); a second instance has MAX_POLLS=3.
module tb_lcd_status_reader;
  import lcd_pkg::*;

  logic       clk = 1'b0;
  logic       rst, start, startB, busGnt;
  logic [1:0] mode;
  logic [7:0] lcdDataIn;

  logic       ready, rdValid, busyFlag, timeout, busReq, lcdRS, lcdRW, lcdE;
  logic [7:0] rdData;
  logic [6:0] addrCnt;
  logic       readyB, rdValidB, busyFlagB, timeoutB, busReqB, lcdRSB, lcdRWB, lcdEB;
  logic [7:0] rdDataB;
  logic [6:0] addrCntB;

  int checks = 0;
  int errors = 0;
  bit selB = 1'b0;
  logic oE, oRS, oValid, oTimeout;

  always #5 clk = ~clk;

  lcd_status_reader dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .ready(ready), .rdValid(rdValid),
    .rdData(rdData), .busyFlag(busyFlag), .addrCnt(addrCnt), .timeout(timeout),
    .busReq(busReq), .busGnt(busGnt), .lcdDataIn(lcdDataIn), .lcdRS(lcdRS), .lcdRW(lcdRW),
    .lcdE(lcdE)
  );

  lcd_status_reader #(.MAX_POLLS(3)) dutB (
    .clk(clk), .rst(rst), .start(startB), .mode(mode), .ready(readyB), .rdValid(rdValidB),
    .rdData(rdDataB), .busyFlag(busyFlagB), .addrCnt(addrCntB), .timeout(timeoutB),
    .busReq(busReqB), .busGnt(busGnt), .lcdDataIn(lcdDataIn), .lcdRS(lcdRSB), .lcdRW(lcdRWB),
    .lcdE(lcdEB)
  );

  always_comb begin
    oE       = selB ? lcdEB    : lcdE;
    oRS      = selB ? lcdRSB   : lcdRS;
    oValid   = selB ? rdValidB : rdValid;
    oTimeout = selB ? timeoutB : timeout;
  end

  // validAt is the posedge number (start edge = 0) that first samples rdValid high.
  task automatic run_read(input bit doStart, input logic [1:0] m, input int changeAfter,
                          input logic [7:0] lateData, input int restartAt,
                          output int validAt, output int validCnt, output int ePulses,
                          output int eHigh, output int rsHigh, output int bothPulse);
    bit prevE = 1'b0;
    validAt = 0; validCnt = 0; ePulses = 0; eHigh = 0; rsHigh = 0; bothPulse = 0;
    if (doStart) begin
      @(negedge clk);
      mode = m;
      if (selB) startB = 1'b1; else start = 1'b1;
      @(negedge clk);
      start = 1'b0; startB = 1'b0;
    end
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      start = (k == restartAt);
      if (oE && !prevE) ePulses++;
      if (oE) eHigh++;
      if (oE && oRS) rsHigh++;
      if (oValid) begin
        validCnt++;
        if (validAt == 0) validAt = k + 1;
      end
      if (oValid && oTimeout) bothPulse++;
      prevE = oE;
      if (ePulses >= changeAfter && !oE) lcdDataIn = lateData;
      if (validCnt > 0 && !oValid) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; startB = 1'b0; mode = 2'b00; busGnt = 1'b1; lcdDataIn = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({ready, rdValid, rdData, busyFlag, addrCnt, timeout, busReq, lcdRS, lcdRW, lcdE}
        !== {1'b1, 22'd0}) begin
      errors++;
      $display("FAIL reset_state got ready=%b valid=%b data=%h bf=%b ac=%h to=%b req=%b rs=%b rw=%b e=%b want ready=1 rest 0",
               ready, rdValid, rdData, busyFlag, addrCnt, timeout, busReq, lcdRS, lcdRW, lcdE);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({readyB, busReqB, lcdEB, rdValidB} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_state_b got %b want 1000", {readyB, busReqB, lcdEB, rdValidB});
    end
  endtask

  task automatic test_status_read();
    int va, vc, ep, eh, rs, bp;
    lcdDataIn = 8'h45;
    run_read(1'b1, MODE_STATUS, 1000, 8'h00, 0, va, vc, ep, eh, rs, bp);
    checks++; if (va !== 10) begin errors++; $display("FAIL status_latency got %0d want 10", va); end
    checks++; if (eh !== 4) begin errors++; $display("FAIL status_ehigh got %0d want 4", eh); end
    checks++; if (vc !== 1) begin errors++; $display("FAIL status_valid_cnt got %0d want 1", vc); end
    checks++; if (rs !== 0) begin errors++; $display("FAIL status_rs got %0d want 0", rs); end
    checks++;
    if ({rdData, busyFlag, addrCnt, ready} !== {8'h45, 1'b0, 7'h45, 1'b1}) begin
      errors++;
      $display("FAIL status_result got data=%h bf=%b ac=%h ready=%b want 45 0 45 1",
               rdData, busyFlag, addrCnt, ready);
    end
  endtask

  task automatic test_poll();
    int va, vc, ep, eh, rs, bp;
    lcdDataIn = 8'h80;
    run_read(1'b1, MODE_POLL, 3, 8'h12, 0, va, vc, ep, eh, rs, bp);
    checks++; if (ep !== 4) begin errors++; $display("FAIL poll_pulses got %0d want 4", ep); end
    checks++; if (vc !== 1) begin errors++; $display("FAIL poll_valid_cnt got %0d want 1", vc); end
    checks++; if (va !== 34) begin errors++; $display("FAIL poll_latency got %0d want 34", va); end
    checks++; if (bp !== 0) begin errors++; $display("FAIL poll_timeout got %0d want 0", bp); end
    checks++;
    if ({rdData, busyFlag, addrCnt} !== {8'h12, 1'b0, 7'h12}) begin
      errors++;
      $display("FAIL poll_result got data=%h bf=%b ac=%h want 12 0 12", rdData, busyFlag, addrCnt);
    end
  endtask

  task automatic test_grant_wait();
    int va, vc, ep, eh, rs, bp;
    int bad = 0;
    lcdDataIn = 8'h9C;
    busGnt = 1'b0;
    @(negedge clk);
    mode = MODE_STATUS; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (lcdE !== 1'b0 || lcdRW !== 1'b0 || busReq !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL grant_wait_bus got %0d bad cycles want 0", bad); end
    busGnt = 1'b1;
    run_read(1'b0, MODE_STATUS, 1000, 8'h00, 0, va, vc, ep, eh, rs, bp);
    checks++; if (va !== 10) begin errors++; $display("FAIL grant_latency got %0d want 10", va); end
    checks++;
    if ({rdData, busyFlag, addrCnt} !== {8'h9C, 1'b1, 7'h1C}) begin
      errors++;
      $display("FAIL grant_result got data=%h bf=%b ac=%h want 9c 1 1c", rdData, busyFlag, addrCnt);
    end
  endtask

  task automatic test_data_read();
    int va, vc, ep, eh, rs, bp;
    int bad = 0;
    lcdDataIn = 8'h41;
    run_read(1'b1, MODE_DATA, 1000, 8'h00, 5, va, vc, ep, eh, rs, bp);
    checks++; if (rs !== 4) begin errors++; $display("FAIL data_rs_during_e got %0d want 4", rs); end
    checks++; if (vc !== 1) begin errors++; $display("FAIL data_valid_cnt got %0d want 1", vc); end
    checks++;
    if ({rdData, busyFlag, addrCnt} !== {8'h41, 1'b1, 7'h1C}) begin
      errors++;
      $display("FAIL data_result got data=%h bf=%b ac=%h want 41 1 1c", rdData, busyFlag, addrCnt);
    end
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (rdValid !== 1'b0 || busReq !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL ignored_start got %0d busy cycles want 0", bad); end
  endtask

  task automatic test_timeout();
    int va, vc, ep, eh, rs, bp;
    selB = 1'b1;
    lcdDataIn = 8'hFF;
    run_read(1'b1, MODE_POLL, 1000, 8'h00, 0, va, vc, ep, eh, rs, bp);
    selB = 1'b0;
    checks++; if (ep !== 3) begin errors++; $display("FAIL timeout_pulses got %0d want 3", ep); end
    checks++; if (bp !== 1) begin errors++; $display("FAIL timeout_with_valid got %0d want 1", bp); end
    checks++; if (va !== 26) begin errors++; $display("FAIL timeout_latency got %0d want 26", va); end
    checks++;
    if ({busyFlagB, addrCntB, rdDataB} !== {1'b1, 7'h7F, 8'hFF}) begin
      errors++;
      $display("FAIL timeout_result got bf=%b ac=%h data=%h want 1 7f ff", busyFlagB, addrCntB, rdDataB);
    end
  endtask

  task automatic test_reset_mid();
    int va, vc, ep, eh, rs, bp;
    int bad = 0;
    bit seenE = 1'b0;
    lcdDataIn = 8'h45;
    @(negedge clk);
    mode = MODE_STATUS; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (lcdE) begin seenE = 1'b1; break; end
    end
    checks++; if (seenE !== 1'b1) begin errors++; $display("FAIL reset_mid_reach_e got 0 want 1"); end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({lcdE, lcdRW, busReq, ready} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_mid_async got e,rw,req,ready=%b want 0001", {lcdE, lcdRW, busReq, ready});
    end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (rdValid !== 1'b0 || ready !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL reset_mid_idle got %0d bad cycles want 0", bad); end
    checks++; if (rdData !== 8'h00) begin errors++; $display("FAIL reset_mid_data got %h want 00", rdData); end
    run_read(1'b1, MODE_STATUS, 1000, 8'h00, 0, va, vc, ep, eh, rs, bp);
    checks++; if (va !== 10) begin errors++; $display("FAIL after_reset_latency got %0d want 10", va); end
    checks++;
    if ({rdData, addrCnt} !== {8'h45, 7'h45}) begin
      errors++;
      $display("FAIL after_reset_result got data=%h ac=%h want 45 45", rdData, addrCnt);
    end
  endtask

  initial begin
    test_reset();
    test_status_read();
    test_poll();
    test_grant_wait();
    test_data_read();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lcd_status_reader.md
Name: lcd_status_reader

Overview:
- Read-side companion to the character-LCD write driver.
- Runs HD44780-style read cycles (RW=1) on the shared 2x16 LCD bus.
  - Status read: busy flag plus 7-bit address counter.
  - Data read: DDRAM/CGRAM byte.
  - Poll: repeated status reads until the busy flag clears.
- Lets the processor side stop using fixed write delays.
- Sits beside the write driver; ownership of the LCD pins is arbitrated by a busReq/busGnt handshake.

Parameters:
- SETUP_CYC, 2: clocks with RS/RW stable and E low before the E pulse.
- EHIGH_CYC, 4: clocks E is held high; data is sampled on the last one.
- HOLD_CYC, 2: clocks with E low and RW still 1 after the pulse.
- MAX_POLLS, 255: maximum status reads in poll mode before timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- start  in  1  request a read; accepted only when ready=1
- mode  in  2  00 status once, 01 data read, 10 poll until not busy, 11 treated as 00
- ready  out  1  idle, can accept start
- rdValid  out  1  one-cycle pulse; results valid
- rdData  out  8  raw byte read
- busyFlag  out  1  rdData[7] of the last status read
- addrCnt  out  7  rdData[6:0] of the last status read
- timeout  out  1  one-cycle pulse, coincident with rdValid, when poll gives up
- busReq  out  1  request ownership of the LCD pins
- busGnt  in  1  ownership granted
- lcdDataIn  in  8  LCD D7..D0 from the pads (pads tristated while lcdRW=1)
- lcdRS  out  1  register select
- lcdRW  out  1  1 = read
- lcdE  out  1  enable strobe

Behaviour:
- Reset values: all outputs 0 except ready=1. Reset is asynchronous; asserting it mid-cycle drops lcdE, lcdRW and busReq immediately. State returns to IDLE and the poll counter clears.
- States: IDLE -> REQ -> SETUP -> EHIGH -> HOLD -> (SETUP | DONE) -> IDLE.
- IDLE:
  - ready=1.
  - start=1 latches mode and goes to REQ; ready drops the next cycle.
  - start while ready=0 is ignored.
- REQ: busReq=1; advance to SETUP on the first cycle busGnt=1. busReq stays 1 through DONE.
- busGnt is sampled only in REQ. Deassertion later is ignored and the transaction completes.
- SETUP: lcdRW=1, lcdRS=(mode==01), lcdE=0 for SETUP_CYC cycles.
- EHIGH: lcdE=1 for EHIGH_CYC cycles. lcdDataIn is registered on the last EHIGH cycle.
- HOLD: lcdE=0, lcdRW=1 for HOLD_CYC cycles.
- Poll decision at the end of HOLD:
  - Re-poll when mode==10, sampled bit7=1 and pollCnt<MAX_POLLS-1: increment pollCnt and return to SETUP. The bus stays owned.
  - Otherwise go to DONE.
- DONE (one cycle):
  - rdValid=1; lcdRW=0, lcdRS=0.
  - rdData updated.
  - busyFlag/addrCnt updated only for status/poll modes; they hold otherwise.
  - timeout=1 if the poll was exhausted with bit7 still 1.
  - busReq drops, pollCnt clears, next state IDLE with ready=1.
- Latency with busGnt already high and defaults: start sampled at edge 0, rdValid high at edge 10, i.e. 2+SETUP_CYC+EHIGH_CYC+HOLD_CYC.
- Each additional poll adds SETUP_CYC+EHIGH_CYC+HOLD_CYC.
- Phase counter width: clog2 of max(SETUP_CYC, EHIGH_CYC, HOLD_CYC)+1. Each parameter must be >= 1.

Optional Feature:
- Macro LCD_READ_4BIT_EN.
- Defined (4-bit interface):
  - Each byte takes two SETUP/EHIGH/HOLD sequences.
  - High nibble from lcdDataIn[7:4] first, then low nibble from lcdDataIn[7:4].
  - lcdDataIn[3:0] is unused.
  - Busy/poll decision is made after the second nibble.
  - Default latency becomes 18.
- Undefined: 8-bit behaviour as above.

Decomposition:
- Shared package lcd_pkg holds:
  - mode encodings (MODE_STATUS=2'b00, MODE_DATA=2'b01, MODE_POLL=2'b10);
  - state encoding;
  - BF bit index 7;
  - instruction codes already used by the write driver.
- One sub-module, lcd_phase_timer: loadable down-counter with a done pulse, shared by the SETUP/EHIGH/HOLD phases.

Test Plan:
- Status read: busGnt tied 1, lcdDataIn=8'h45, start with mode 00 -> lcdE high for 4 cycles, rdValid at edge 10, rdData=8'h45, busyFlag=0, addrCnt=7'h45.
- Poll: lcdDataIn=8'h80 for the first 3 reads, then 8'h12 -> exactly 4 E pulses, rdValid once, busyFlag=0, addrCnt=7'h12, timeout=0.
- Timeout: MAX_POLLS=3, lcdDataIn stuck at 8'hFF -> 3 E pulses, then rdValid and timeout pulse together, busyFlag=1.
- Grant wait: busGnt held 0 for 20 cycles after start -> lcdE/lcdRW stay 0 and busReq=1 throughout; read proceeds on the first cycle busGnt=1.
- Data read and ignored start: mode 01 with lcdDataIn=8'h41 -> lcdRS=1 during the cycle, rdData=8'h41, busyFlag/addrCnt unchanged; a second start pulsed mid-read is ignored.
- Reset mid-EHIGH: rst=0 -> lcdE/lcdRW/busReq drop immediately, ready=1 after release, no rdValid; the next start reads normally.
